// File: rtl/aurora_rx_frame_buffer.sv
// Store-and-forward frame buffer: absorbs an Aurora RX stream that has no tready
// and forwards only complete frames, with backpressure, on an AXI-Stream master.
module aurora_rx_frame_buffer #(
  parameter int DATA_WIDTH      = 32,
  parameter int DEPTH           = 512,
  parameter int MAX_FRAME_WORDS = 64
) (
  input  logic                    m_axis_aclk,
  input  logic                    reset,
  input  logic                    s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tlast,
  output logic                    m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  input  logic                    ctrl_rst_cntr,
  output logic [$clog2(DEPTH):0]  frames_stored,
  output logic [31:0]             drop_cnt,
  output logic                    ovf_sticky
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(MAX_FRAME_WORDS + 1);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [LW-1:0] MAX_LEN  = LW'(MAX_FRAME_WORDS);

  localparam logic [1:0] ST_SYNC   = 2'd0;
  localparam logic [1:0] ST_IDLE   = 2'd1;
  localparam logic [1:0] ST_ACCEPT = 2'd2;
  localparam logic [1:0] ST_DROP   = 2'd3;

  logic                  rst_meta, rst_int;
  logic [DATA_WIDTH:0]   mem [DEPTH];
  logic [AW:0]           wr_ptr, commit_ptr, rd_ptr, start_ptr, used;
  logic [LW-1:0]         frame_len;
  logic [1:0]            state;
  logic                  full, wr_en, commit, drop;
  logic                  fetch, inflight, pop, head;
  logic [1:0]            cnt;
  logic [DATA_WIDTH:0]   mem_q;
  logic [DATA_WIDTH:0]   skid [2];

  // Assert asynchronously, release two clocks after the external reset drops.
  always_ff @(posedge m_axis_aclk or posedge reset) begin
    if (reset) begin
      rst_meta <= 1'b1;
      rst_int  <= 1'b1;
    end else begin
      rst_meta <= 1'b0;
      rst_int  <= rst_meta;
    end
  end

  assign used = wr_ptr - rd_ptr;
  assign full = (used == FULL_LVL);

  always_comb begin
    wr_en  = 1'b0;
    commit = 1'b0;
    drop   = 1'b0;
    if (s_axis_tvalid) begin
      case (state)
        ST_IDLE: begin
          if (!full) begin
            wr_en  = 1'b1;
            commit = s_axis_tlast;
          end else begin
            drop = 1'b1;
          end
        end
        ST_ACCEPT: begin
          if (full || frame_len == MAX_LEN) begin
            drop = 1'b1;
          end else begin
            wr_en  = 1'b1;
            commit = s_axis_tlast;
          end
        end
        default: ;
      endcase
    end
  end

  // An aborted frame rewinds wr_ptr to its start, so partial words are simply overwritten.
  always_ff @(posedge m_axis_aclk or posedge rst_int) begin
    if (rst_int) begin
      state      <= ST_SYNC;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      start_ptr  <= '0;
      frame_len  <= '0;
    end else begin
      if (wr_en)  wr_ptr     <= wr_ptr + 1'b1;
      if (commit) commit_ptr <= wr_ptr + 1'b1;
      if (s_axis_tvalid) begin
        case (state)
          ST_SYNC: if (s_axis_tlast) state <= ST_IDLE;
          ST_IDLE: begin
            if (wr_en) begin
              start_ptr <= wr_ptr;
              frame_len <= LW'(1);
              if (!s_axis_tlast) state <= ST_ACCEPT;
            end else if (!s_axis_tlast) begin
              state <= ST_DROP;
            end
          end
          ST_ACCEPT: begin
            if (drop) begin
              wr_ptr <= start_ptr;
              state  <= s_axis_tlast ? ST_IDLE : ST_DROP;
            end else begin
              frame_len <= frame_len + LW'(1);
              if (s_axis_tlast) state <= ST_IDLE;
            end
          end
          default: if (s_axis_tlast) state <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge m_axis_aclk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
  end

  // Fetch only committed words, and only if the skid pair can absorb the word in flight.
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign fetch         = (rd_ptr != commit_ptr) &&
                         (({1'b0, cnt} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
  assign m_axis_tvalid = (cnt != 2'd0);
  assign m_axis_tdata  = skid[head][DATA_WIDTH-1:0];
  assign m_axis_tlast  = skid[head][DATA_WIDTH];

  always_ff @(posedge m_axis_aclk) begin
    if (fetch) mem_q <= mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge m_axis_aclk or posedge rst_int) begin
    if (rst_int) begin
      rd_ptr   <= '0;
      inflight <= 1'b0;
      cnt      <= 2'd0;
      head     <= 1'b0;
      skid[0]  <= '0;
      skid[1]  <= '0;
    end else begin
      if (fetch) rd_ptr <= rd_ptr + 1'b1;
      inflight <= fetch;
      if (inflight) skid[head ^ cnt[0]] <= mem_q;
      cnt  <= cnt + {1'b0, inflight} - {1'b0, pop};
      head <= head ^ pop;
    end
  end

  always_ff @(posedge m_axis_aclk or posedge rst_int) begin
    if (rst_int) begin
      frames_stored <= '0;
    end else if (commit && !(pop && m_axis_tlast)) begin
      frames_stored <= frames_stored + 1'b1;
    end else if (!commit && pop && m_axis_tlast) begin
      frames_stored <= frames_stored - 1'b1;
    end
  end

  always_ff @(posedge m_axis_aclk or posedge rst_int) begin
    if (rst_int) begin
      drop_cnt   <= '0;
      ovf_sticky <= 1'b0;
    end else if (ctrl_rst_cntr) begin
      drop_cnt   <= '0;
      ovf_sticky <= 1'b0;
    end else if (drop) begin
      if (drop_cnt != 32'hFFFF_FFFF) drop_cnt <= drop_cnt + 1'b1;
      ovf_sticky <= 1'b1;
    end
  end
endmodule
